seg7_scan: RTL and testbench

Downstream display stage for the debug-value multiplexer. Takes the selected 32-bit display word (PC, cycle count, branch/jump statistics, memory data or syscall output) and time-multiplexes it as 8 hexadecimal digits onto the board's common-anode 7-segment array. The word is sampled once per scan frame so a value changing mid-scan never shows torn digits. Optional leading-zero blanking and per-digit decimal points are included.

---
 rtl/seg7_scan.sv | 123 ++++++++++++
 tb/tb_seg7_scan.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// Scans a 32-bit word as 8 hex digits onto a common-anode 7-segment array.
// The word and decimal-point mask are captured once per frame so a frame never shows torn digits.
module seg7_scan #(
    parameter int CLK_DIV  = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int             DW      = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE = DW'(1);

    // Active-low hex font, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [DW-1:0] div_cnt_r;
    logic [2:0]    dig_r;
    logic [31:0]   data_q_r;
    logic [7:0]    dpm_q_r;
    logic          init_r;
    logic          load_d_r;
    logic          frame_start_r;
    logic [7:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tick_s;
    logic          load_s;
    logic [31:0]   shifted_s;
    logic [3:0]    nib_s;
    logic          blank_s;

    // Divider tick and frame-load decision
    always_comb begin
        tick_s = (div_cnt_r == DIV_MAX);
        load_s = init_r | (tick_s & (dig_r == 3'd7));
    end

    // Current nibble and leading-zero test: digit k is blank when every nibble from k upward is zero
    always_comb begin
        shifted_s = data_q_r >> {dig_r, 2'b00};
        nib_s     = shifted_s[3:0];
        if (BLANK_LZ && (dig_r != 3'd0) && (shifted_s == 32'd0)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end

    // Scan state, frame capture and registered display outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_r     <= '0;
            dig_r         <= 3'd0;
            data_q_r      <= 32'd0;
            dpm_q_r       <= 8'd0;
            init_r        <= 1'b1;
            load_d_r      <= 1'b0;
            frame_start_r <= 1'b0;
            an_r          <= 8'hFF;
            seg_r         <= 7'h7F;
            dp_r          <= 1'b1;
        end else begin
            div_cnt_r <= tick_s ? '0 : div_cnt_r + DIV_ONE;
            if (tick_s) begin
                dig_r <= dig_r + 3'd1;
            end
            if (load_s) begin
                data_q_r <= data_in;
                dpm_q_r  <= dp_mask;
            end
            init_r <= 1'b0;
            // Two stages so the pulse lines up with digit 0 of the new sample reaching the pins
            load_d_r      <= load_s;
            frame_start_r <= load_d_r;
            if (blank_s) begin
                an_r  <= 8'hFF;
                seg_r <= 7'h7F;
                dp_r  <= 1'b1;
            end else begin
                an_r  <= ~(8'h01 << dig_r);
                seg_r <= hex_to_seg(nib_s);
                dp_r  <= ~dpm_q_r[dig_r];
            end
        end
    end

    assign an          = an_r;
    assign seg         = seg_r;
    assign dp          = dp_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: two instances (no blanking / blanking) with CLK_DIV=4.
// Stimulus queues expected frames tagged by frame number; a monitor checks every displayed cycle.
module tb_seg7_scan;

    localparam int DIV = 4;
    localparam logic [6:0] HEX7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        int          inst;
        int          idx;
        logic [31:0] data;
        logic [7:0]  dpm;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] data_w [2];
    logic [7:0]  dpm_w  [2];
    logic [7:0]  an_w   [2];
    logic [6:0]  seg_w  [2];
    logic        dp_w   [2];
    logic        fs_w   [2];

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    seg7_scan #(.CLK_DIV(DIV), .BLANK_LZ(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .data_in(data_w[0]), .dp_mask(dpm_w[0]),
        .an(an_w[0]), .seg(seg_w[0]), .dp(dp_w[0]), .frame_start(fs_w[0])
    );

    seg7_scan #(.CLK_DIV(DIV), .BLANK_LZ(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_w[1]), .dp_mask(dpm_w[1]),
        .an(an_w[1]), .seg(seg_w[1]), .dp(dp_w[1]), .frame_start(fs_w[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected {an, seg, dp} for digit k of a frame
    function automatic logic [15:0] model(logic [31:0] d, logic [7:0] m, bit blz, int k);
        logic [31:0] sh;
        logic [7:0]  a;
        logic [3:0]  nib;
        sh  = d >> (4 * k);
        nib = sh[3:0];
        a   = 8'h01 << k;
        if (blz && (k != 0) && (sh == 32'd0)) begin
            return {8'hFF, 7'h7F, 1'b1};
        end
        return {~a, HEX7[nib], ~m[k]};
    endfunction

    task automatic push(int g, int idx, logic [31:0] d, logic [7:0] m);
        exp_t e;
        e.inst = g;
        e.idx  = idx;
        e.data = d;
        e.dpm  = m;
        exp_q.push_back(e);
    endtask

    task automatic chk(string name, logic [16:0] act, logic [16:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic monitor_loop();
        int   fidx  [2];
        int   cyc   [2];
        bit   act   [2];
        bit   first [2];
        bit   cfirst[2];
        exp_t cur   [2];
        int   d;
        int   len;
        logic [15:0] e;
        logic [15:0] a;
        for (int g = 0; g < 2; g++) begin
            fidx[g] = 0; cyc[g] = 0; act[g] = 1'b0; first[g] = 1'b1; cfirst[g] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    act[g]   = 1'b0;
                    fidx[g]  = 0;
                    first[g] = 1'b1;
                end else begin
                    if (fs_w[g]) begin
                        if (act[g]) begin
                            len = cfirst[g] ? 8 * DIV - 1 : 8 * DIV;
                            n_cmp++;
                            if (cyc[g] != len) begin
                                n_fail++;
                                $display("FAIL frame_len inst%0d frame%0d: got %0d cycles expected %0d",
                                         g, fidx[g], cyc[g], len);
                            end
                        end
                        fidx[g]++;
                        cfirst[g] = first[g];
                        first[g]  = 1'b0;
                        act[g]    = 1'b0;
                        cyc[g]    = 0;
                        for (int i = 0; i < exp_q.size(); i++) begin
                            if (!act[g] && exp_q[i].inst == g && exp_q[i].idx == fidx[g]) begin
                                cur[g] = exp_q[i];
                                exp_q.delete(i);
                                act[g] = 1'b1;
                            end
                        end
                    end
                    if (act[g]) begin
                        // The first frame after reset loses one digit-0 cycle to the init load
                        d = (cyc[g] + (cfirst[g] ? 1 : 0)) / DIV;
                        if (d < 8) begin
                            e = model(cur[g].data, cur[g].dpm, (g == 1), d);
                            a = {an_w[g], seg_w[g], dp_w[g]};
                            n_cmp++;
                            if (a !== e) begin
                                n_fail++;
                                $display("FAIL digit inst%0d frame%0d digit%0d cyc%0d: got an=%h seg=%h dp=%b expected an=%h seg=%h dp=%b",
                                         g, fidx[g], d, cyc[g], a[15:8], a[7:1], a[0], e[15:8], e[7:1], e[0]);
                            end
                        end
                        cyc[g]++;
                    end
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        data_w[0] = 32'h0123ABCD; dpm_w[0] = 8'h05;
        data_w[1] = 32'h000000F0; dpm_w[1] = 8'h00;
        fork
            monitor_loop();
        join_none

        wait_cyc(2);
        chk("reset0", {an_w[0], seg_w[0], dp_w[0], fs_w[0]}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        chk("reset1", {an_w[1], seg_w[1], dp_w[1], fs_w[1]}, {8'hFF, 7'h7F, 1'b1, 1'b0});

        rst = 1'b0;
        push(0, 1, 32'h0123ABCD, 8'h05);
        push(0, 2, 32'h0123ABCD, 8'h05);
        push(1, 1, 32'h000000F0, 8'h00);
        push(1, 2, 32'h000000F0, 8'h00);
        wait_cyc(1);
        chk("fs_c1_0", {16'h0, fs_w[0]}, 17'h0);
        chk("fs_c1_1", {16'h0, fs_w[1]}, 17'h0);
        wait_cyc(1);
        chk("fs_c2_0", {16'h0, fs_w[0]}, 17'h1);
        chk("fs_c2_1", {16'h0, fs_w[1]}, 17'h1);

        // Lands in frame 3 (loaded at cycle 64)
        wait_cyc(38);
        data_w[0] = 32'h11111111;
        data_w[1] = 32'h00000000;
        push(0, 3, 32'h11111111, 8'h05);
        push(1, 3, 32'h00000000, 8'h00);

        wait_cyc(30);
        data_w[1] = 32'h00000001; dpm_w[1] = 8'h04;
        push(1, 4, 32'h00000001, 8'h04);

        // Cycle 78 is digit 3 of frame 3: the new word must wait for frame 4
        wait_cyc(8);
        data_w[0] = 32'h22222222;
        push(0, 4, 32'h22222222, 8'h05);

        // Cycle 150 is digit 5 of frame 5: assert reset between edges
        wait_cyc(72);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst0", {an_w[0], seg_w[0], dp_w[0], fs_w[0]}, {8'hFF, 7'h7F, 1'b1, 1'b0});
        chk("async_rst1", {an_w[1], seg_w[1], dp_w[1], fs_w[1]}, {8'hFF, 7'h7F, 1'b1, 1'b0});

        wait_cyc(1);
        data_w[0] = 32'h89ABCDEF; dpm_w[0] = 8'h80;
        data_w[1] = 32'h00003000; dpm_w[1] = 8'hFF;
        rst = 1'b0;
        push(0, 1, 32'h89ABCDEF, 8'h80);
        push(0, 2, 32'h89ABCDEF, 8'h80);
        push(1, 1, 32'h00003000, 8'hFF);
        push(1, 2, 32'h00003000, 8'hFF);
        wait_cyc(1);
        chk("fs_r1_0", {16'h0, fs_w[0]}, 17'h0);
        chk("fs_r1_1", {16'h0, fs_w[1]}, 17'h0);
        wait_cyc(1);
        chk("fs_r2_0", {16'h0, fs_w[0]}, 17'h1);
        chk("fs_r2_1", {16'h0, fs_w[1]}, 17'h1);
        wait_cyc(38);

        chk("frames_left", {1'b0, 16'(exp_q.size())}, 17'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
